// File: rtl/distance_job_driver.sv
// Initiator for the distance calculator start/done handshake: accepts a job, pulses start,
// waits for a fresh done (or timeout) and returns the result. Optional stats: DRV_STATS_EN.
module distance_job_driver #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned START_HOLD = 2,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              calc_start,
    output logic [DATA_W-1:0] calc_a,
    output logic [DATA_W-1:0] calc_b,
    input  logic              calc_done,
    input  logic [DATA_W-1:0] calc_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_timeout,
`ifdef DRV_STATS_EN
    output logic [7:0]        jobs_ok,
    output logic [7:0]        jobs_tmo,
`endif
    output logic [DATA_W-1:0] rsp_result
);

    localparam int unsigned HOLD_W = $clog2(START_HOLD + 1);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(START_HOLD - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS     = 3'd1,
        RELEASE   = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } state_t;

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [TMO_W-1:0]  tmo_cnt;

`ifdef DRV_STATS_EN
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction
`endif

    // Single-process FSM; every output is a register updated on transitions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            calc_start  <= 1'b0;
            calc_a      <= '0;
            calc_b      <= '0;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_timeout <= 1'b0;
            hold_cnt    <= '0;
            tmo_cnt     <= '0;
`ifdef DRV_STATS_EN
            jobs_ok     <= '0;
            jobs_tmo    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        calc_a     <= req_a;
                        calc_b     <= req_b;
                        hold_cnt   <= HOLD_LOAD;
                        calc_start <= 1'b1;
                        req_ready  <= 1'b0;
                        state      <= PRESS;
                    end
                end
                PRESS: begin
                    if (hold_cnt == '0) begin
                        calc_start <= 1'b0;
                        tmo_cnt    <= '0;
                        state      <= RELEASE;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                RELEASE, WAIT_DONE: begin
                    // A done seen in RELEASE is stale; only WAIT_DONE may capture.
                    if (state == WAIT_DONE && calc_done) begin
                        rsp_result  <= calc_result;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
`ifdef DRV_STATS_EN
                        jobs_ok     <= sat_inc(jobs_ok);
`endif
                    end else if (state == RELEASE && !calc_done) begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                        state   <= WAIT_DONE;
                    end else if (tmo_cnt >= TMO_LAST) begin
                        rsp_result  <= '0;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
`ifdef DRV_STATS_EN
                        jobs_tmo    <= sat_inc(jobs_tmo);
`endif
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    calc_start <= 1'b0;
                    rsp_valid  <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_distance_job_driver.sv
// Directed self-checking bench for distance_job_driver (stats checks when DRV_STATS_EN is defined).
module tb_distance_job_driver;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned START_HOLD = 2;
    localparam int unsigned TIMEOUT    = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic              calc_start;
    logic [DATA_W-1:0] calc_a;
    logic [DATA_W-1:0] calc_b;
    logic              calc_done;
    logic [DATA_W-1:0] calc_result;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_timeout;
    logic [DATA_W-1:0] rsp_result;
`ifdef DRV_STATS_EN
    logic [7:0]        jobs_ok;
    logic [7:0]        jobs_tmo;
`endif

    int checks = 0;
    int errors = 0;

    distance_job_driver #(
        .DATA_W    (DATA_W),
        .START_HOLD(START_HOLD),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .calc_start (calc_start),
        .calc_a     (calc_a),
        .calc_b     (calc_b),
        .calc_done  (calc_done),
        .calc_result(calc_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_timeout(rsp_timeout),
`ifdef DRV_STATS_EN
        .jobs_ok    (jobs_ok),
        .jobs_tmo   (jobs_tmo),
`endif
        .rsp_result (rsp_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a job and watch the start pulse; returns one step after start falls.
    task automatic start_job(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        int hi;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("accept_ready", 32'(req_ready), 32'd0);
        check("accept_a", 32'(calc_a), 32'(a));
        check("accept_b", 32'(calc_b), 32'(b));
        hi = 0;
        for (int n = 0; n < 10 && calc_start; n++) begin
            hi++;
            tick();
        end
        check("start_hold", 32'(hi), 32'(START_HOLD));
    endtask

    // Raise done after 'delay' steps and expect the response one step later.
    task automatic finish_done(input int delay, input logic [DATA_W-1:0] res);
        for (int i = 0; i < delay; i++) begin
            tick();
        end
        check("pre_done_valid", 32'(rsp_valid), 32'd0);
        calc_done   = 1'b1;
        calc_result = res;
        tick();
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_result", 32'(rsp_result), 32'(res));
        check("rsp_timeout", 32'(rsp_timeout), 32'd0);
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        calc_done = 1'b0;
        check("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_rsp_ready", 32'(req_ready), 32'd1);
    endtask

    // Expect a timeout response exactly TIMEOUT steps after start release.
    task automatic expect_timeout();
        int cnt;
        cnt = 0;
        for (int n = 0; n < 200 && !rsp_valid; n++) begin
            tick();
            cnt++;
        end
        check("tmo_cycles", 32'(cnt), 32'(TIMEOUT));
        check("tmo_flag", 32'(rsp_timeout), 32'd1);
        check("tmo_result", 32'(rsp_result), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] held;
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_a       = '0;
        req_b       = '0;
        calc_done   = 1'b0;
        calc_result = '0;
        rsp_ready   = 1'b0;
        tick();
        tick();
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_calc_start", 32'(calc_start), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_calc_a", 32'(calc_a), 32'd0);
        check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        reset = 1'b0;
        tick();

        // Basic job
        start_job(16'd3, 16'd40);
        finish_done(20, 16'h0025);
        take_rsp();

        // Stale done from previous job must be ignored
        calc_done   = 1'b1;
        calc_result = 16'hBEEF;
        start_job(16'd7, 16'd9);
        tick();
        check("stale_hold_valid", 32'(rsp_valid), 32'd0);
        calc_done = 1'b0;
        tick();
        check("stale_drop_valid", 32'(rsp_valid), 32'd0);
        finish_done(3, 16'h0011);
        take_rsp();

        // Timeout with done stuck low
        start_job(16'h1234, 16'h5678);
        expect_timeout();
        take_rsp();

        // Backpressure, with a new request held off during RESP
        start_job(16'hAAAA, 16'h5555);
        finish_done(2, 16'h0C0D);
        held      = rsp_result;
        req_a     = 16'h0F0F;
        req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_result", 32'(rsp_result), 32'(held));
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_calc_a", 32'(calc_a), 32'hAAAA);
        end
        req_valid = 1'b0;
        take_rsp();
        check("bp_calc_a_idle", 32'(calc_a), 32'hAAAA);

        // Reset during PRESS drops start asynchronously
        req_a     = 16'd5;
        req_b     = 16'd6;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("press_start", 32'(calc_start), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_press_start", 32'(calc_start), 32'd0);
        check("rst_press_ready", 32'(req_ready), 32'd1);
        tick();
        reset = 1'b0;
        tick();

        // Reset during WAIT_DONE discards the in-flight job
        start_job(16'd11, 16'd12);
        tick();
        #2 reset = 1'b1;
        #1;
        check("rst_wait_start", 32'(calc_start), 32'd0);
        check("rst_wait_valid", 32'(rsp_valid), 32'd0);
        check("rst_wait_ready", 32'(req_ready), 32'd1);
        tick();
        reset       = 1'b0;
        calc_done   = 1'b1;
        calc_result = 16'h0077;
        tick();
        tick();
        check("rst_no_rsp", 32'(rsp_valid), 32'd0);
        check("rst_idle_ready", 32'(req_ready), 32'd1);
        calc_done = 1'b0;
        tick();

`ifdef DRV_STATS_EN
        check("stats_ok_rst", 32'(jobs_ok), 32'd0);
        check("stats_tmo_rst", 32'(jobs_tmo), 32'd0);
        for (int j = 0; j < 300; j++) begin
            start_job(16'(j), 16'(j + 1));
            finish_done(1, 16'(j + 100));
            take_rsp();
        end
        for (int j = 0; j < 2; j++) begin
            start_job(16'd1, 16'd2);
            expect_timeout();
            take_rsp();
        end
        check("stats_ok_sat", 32'(jobs_ok), 32'd255);
        check("stats_tmo", 32'(jobs_tmo), 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
